// File: rtl/code_lock_pkg.sv
// code_lock_pkg: constants and FSM state encodings shared by the code lock blocks
package code_lock_pkg;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYCLES = 200;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D1   = 3'd1,
    S_D2   = 3'd2,
    S_R1   = 3'd3,
    S_OPEN = 3'd4,
    S_FAIL = 3'd5,
    S_LOCK = 3'd6
  } lock_state_e;
endpackage

// File: rtl/code_input_ctrl_debounce.sv
// button_debounce: two-flop synchronizer, debounce filter and press pulse for one button
//   clk, reset (async active-low), btn_i raw level, press_o high the cycle after the accepted level rises
module button_debounce import code_lock_pkg::*; #(
  parameter int CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int W = $clog2(CYCLES + 1);
  logic [1:0] sync_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic acc_q, acc_d, prev_q, hit;
  // the CYCLES-th consecutive mismatching sample flips the level instead of storing CYCLES
  always_comb begin
    hit = (sync_q[1] != acc_q) && (cnt_q == W'(CYCLES - 1));
    cnt_d = (sync_q[1] == acc_q || hit) ? '0 : cnt_q + 1'b1;
    acc_d = hit ? ~acc_q : acc_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      prev_q <= acc_q;
    end
  assign press_o = acc_q & ~prev_q;
endmodule

// File: rtl/code_input_ctrl.sv
// code_input_ctrl: button front end, inactivity timer and failed-attempt lockout for the code lock
//   clk, reset (async active-low); btn_d/btn_r raw buttons; en/encnt from the lock FSM
//   Din/Rin/nDin/nRin/anyIN one-cycle press events; timeOut pulse; cntOut lockout level
module code_input_ctrl import code_lock_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = code_lock_pkg::DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES = code_lock_pkg::TIMEOUT_CYCLES,
  parameter int MAX_TRIES = code_lock_pkg::MAX_TRIES,
  parameter int LOCK_CYCLES = code_lock_pkg::LOCK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_d,
  input  logic btn_r,
  input  logic en,
  input  logic encnt,
  output logic Din,
  output logic Rin,
  output logic nDin,
  output logic nRin,
  output logic anyIN,
  output logic timeOut,
  output logic cntOut
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  logic d_ev, r_ev, ev, idle_hit, enc_rise, lock_end;
  logic [4:0] ev_q, ev_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [TW-1:0] try_q, try_d;
  logic [LW-1:0] lock_q, lock_d;
  logic to_q, to_d, enc_q, cnt_q, cnt_d;
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_d (.clk(clk), .reset(reset), .btn_i(btn_d), .press_o(d_ev));
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_r (.clk(clk), .reset(reset), .btn_i(btn_r), .press_o(r_ev));
  // ev_q packs {Din, Rin, nDin, nRin, anyIN}; a joint press counts as neither D nor R
  always_comb begin
    ev = d_ev | r_ev;
    ev_d = {d_ev & ~r_ev, r_ev & ~d_ev, r_ev, d_ev, ev};
    idle_hit = idle_q == IW'(TIMEOUT_CYCLES - 1);
    to_d = en & ~ev & ~cnt_q & idle_hit;
    idle_d = (!en || ev || cnt_q || idle_hit) ? '0 : idle_q + 1'b1;
    enc_rise = encnt & ~enc_q;
    lock_end = cnt_q && (lock_q == LW'(LOCK_CYCLES - 1));
    lock_d = (cnt_q && !lock_end) ? lock_q + 1'b1 : '0;
    cnt_d = cnt_q ? !lock_end : (try_q == TW'(MAX_TRIES));
    try_d = lock_end ? '0 : (enc_rise && !cnt_q && try_q != TW'(MAX_TRIES)) ? try_q + 1'b1 : try_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ev_q <= '0;
      idle_q <= '0;
      to_q <= 1'b0;
      enc_q <= 1'b0;
      try_q <= '0;
      lock_q <= '0;
      cnt_q <= 1'b0;
    end else begin
      ev_q <= ev_d;
      idle_q <= idle_d;
      to_q <= to_d;
      enc_q <= encnt;
      try_q <= try_d;
      lock_q <= lock_d;
      cnt_q <= cnt_d;
    end
  assign {Din, Rin, nDin, nRin, anyIN} = ev_q;
  assign timeOut = to_q;
  assign cntOut = cnt_q;
endmodule

// File: doc/code_input_ctrl.md
Name: code_input_ctrl

Overview:
- Front end for the two-button code-lock FSM: synchronizes and debounces the raw D and R buttons.
- Converts accepted presses into one-cycle event pulses: Din, Rin, nDin, nRin, anyIN.
- Owns the inactivity timer (timeOut) and the failed-attempt counter (cntOut).
- The lock FSM drives en/encnt into this block and consumes its outputs.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples before a button level is accepted.
- TIMEOUT_CYCLES, 1000: idle cycles with en high before timeOut pulses.
- MAX_TRIES, 3: failed attempts that trigger lockout.
- LOCK_CYCLES, 200: cycles cntOut stays high during lockout.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- btn_d  input  1  raw D button, active-high, asynchronous to clk
- btn_r  input  1  raw R button, active-high, asynchronous to clk
- en  input  1  from FSM: inactivity timer enabled while high
- encnt  input  1  from FSM: level; each rising edge counts one failed attempt
- Din  output  1  pulse: D press accepted
- Rin  output  1  pulse: R press accepted
- nDin  output  1  pulse: a non-D press accepted
- nRin  output  1  pulse: a non-R press accepted
- anyIN  output  1  pulse: any press accepted
- timeOut  output  1  pulse: inactivity timeout
- cntOut  output  1  level: lockout active

Behaviour:
- Reset (reset=0): all outputs 0; sync flops, debounce counters, accepted levels, idle timer, try counter and lock timer all 0. Reset is asynchronous and may occur mid-debounce, mid-timeout or mid-lockout; all state returns to 0.
- Synchronizer: two flops per button.
- Debounce:
  - Per-button counter; counting runs while the synchronized level differs from the accepted level, and the counter clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press event: a rising edge of an accepted level. Latency from raw edge to pulse is 2 sync cycles + DEBOUNCE_CYCLES + 1 registered output cycle. Releases generate no pulses.
- Event decode (registered, one cycle wide):
  - D only: Din=1, nRin=1, anyIN=1.
  - R only: Rin=1, nDin=1, anyIN=1.
  - D and R accepted in the same cycle: nDin=1, nRin=1, anyIN=1; Din=0, Rin=0.
- Idle timer:
  - Clears when en=0, on any accepted press event, or when cntOut=1.
  - Otherwise increments while en=1.
  - On reaching TIMEOUT_CYCLES-1, timeOut pulses high the next cycle and the timer clears, so it re-arms.
- Attempt counter:
  - Edge-detects encnt with a registered previous value.
  - Increments on a rising edge, saturating at MAX_TRIES.
  - When the count equals MAX_TRIES, cntOut rises on the next cycle.
- Lockout:
  - While cntOut=1, the lock timer counts.
  - After LOCK_CYCLES cycles high, cntOut falls, the try count clears and the lock timer clears.
  - encnt edges during lockout are ignored.
  - Button events are still decoded during lockout; the FSM owns the consequence.
- Simultaneous events: a press event in the same cycle as the timeout terminal count clears the timer, and timeOut does not pulse.
- Widths: counters are sized by $clog2(param+1); no wrap-around, since every counter clears or saturates before overflow.

Decomposition:
- Shared package code_lock_pkg holds the default constants (DEBOUNCE_CYCLES, TIMEOUT_CYCLES, MAX_TRIES, LOCK_CYCLES) and the 3-bit FSM state encodings, so the FSM and this block share one source.
- Natural sub-module: button_debounce (sync + debounce + rising-edge pulse), instantiated twice. Event decode, idle timer and attempt/lockout logic stay in code_input_ctrl.

Test Plan:
- Reset low 5 cycles, release; btn_d held 30 cycles -> Din, nRin, anyIN each high exactly 1 cycle, at cycle 2+16+1=19 after the btn_d rise; Rin, nDin stay 0.
- btn_r glitch high 10 cycles, then low -> no output pulses. Then btn_r held 40 cycles -> one Rin/nDin/anyIN pulse.
- btn_d and btn_r rise in the same cycle -> single-cycle nDin=nRin=anyIN=1, Din=Rin=0.
- en=1, no presses -> timeOut pulses at cycle 1000 and 2000. Repeat with a D press at cycle 900 -> no pulse until cycle 900+latency+1000.
- Three encnt 0->1->0 edges -> cntOut rises 1 cycle after the third edge and stays high 200 cycles. A fourth encnt edge during lockout has no effect. After lockout one more edge leaves cntOut=0 (count=1).
- Assert reset mid-lockout (cycle 100 of 200) -> cntOut=0 immediately (asynchronous); after release, 2 encnt edges leave cntOut=0.
